// File: rtl/img_sched_pkg.sv
// rtl/img_sched_pkg.sv - shared constants and FSM state encoding for img_window_sched
// Ports: none (package).
// Default geometry plus the values derived from it. Modules take their own
// parameters and derive locally, so non-default builds stay consistent.
package img_sched_pkg;

  localparam int IMG_W_DEF         = 14;
  localparam int IMG_H_DEF         = 14;
  localparam int K_DEF             = 3;
  localparam int LOAD_ADDR_LEN_DEF = 7;

  localparam int OUT_W  = IMG_W_DEF - K_DEF + 1;
  localparam int OUT_H  = IMG_H_DEF - K_DEF + 1;
  localparam int TAPS   = K_DEF * K_DEF;
  localparam int ADDR_W = LOAD_ADDR_LEN_DEF + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/win_addr_gen.sv
// rtl/win_addr_gen.sv - nested window counters and port-1 read address generator
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   advance          step to the next tap (one issue)
//   addr1            port-1 address for the current tap
//   tap              tap index kr*K+kc of the current tap
//   r, c             output row / even output column of the current tap
//   last             current tap is the final one of the pass
module win_addr_gen
  import img_sched_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int K      = K_DEF,
  parameter int ADDR_W = LOAD_ADDR_LEN_DEF + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr1,
  output logic [3:0]        tap,
  output logic [3:0]        r,
  output logic [3:0]        c,
  output logic              last
);

  localparam int NCOL = IMG_W - K + 1;
  localparam int NROW = IMG_H - K + 1;

  localparam logic [3:0]        K_MAX    = 4'(K - 1);
  localparam logic [3:0]        TAP_MAX  = 4'(K * K - 1);
  localparam logic [3:0]        C_MAX    = 4'(NCOL - 2);
  localparam logic [3:0]        R_MAX    = 4'(NROW - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  logic [3:0]        kc;
  logic [3:0]        kr;
  // row_base = r*IMG_W and kr_off = kr*IMG_W, kept as running sums
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] kr_off;

  always_ff @(posedge clk) begin
    if (rst) begin
      kc       <= '0;
      kr       <= '0;
      c        <= '0;
      r        <= '0;
      tap      <= '0;
      row_base <= '0;
      kr_off   <= '0;
    end else if (advance) begin
      tap <= (tap == TAP_MAX) ? 4'd0 : tap + 4'd1;
      if (kc != K_MAX) begin
        kc <= kc + 4'd1;
      end else begin
        kc <= '0;
        if (kr != K_MAX) begin
          kr     <= kr + 4'd1;
          kr_off <= kr_off + ROW_STEP;
        end else begin
          kr     <= '0;
          kr_off <= '0;
          if (c != C_MAX) begin
            c <= c + 4'd2;
          end else begin
            c <= '0;
            // wraps to zero after the last tap so the next pass starts clean
            if (r != R_MAX) begin
              r        <= r + 4'd1;
              row_base <= row_base + ROW_STEP;
            end else begin
              r        <= '0;
              row_base <= '0;
            end
          end
        end
      end
    end
  end

  assign addr1 = row_base + kr_off + ADDR_W'(c) + ADDR_W'(kc);
  assign last  = (r == R_MAX) && (c == C_MAX) && (kr == K_MAX) && (kc == K_MAX);

endmodule

// File: rtl/img_window_sched.sv
// rtl/img_window_sched.sv - KxK window read scheduler for the 16-channel image bank
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin one channel-image pass (honoured in IDLE only)
//   stall                 downstream back-pressure, freezes issue
//   mem_load              read enable to the memory bank
//   addr1, addr2          read addresses for output columns c and c+1
//   tap_valid             memory outputs carry a valid tap this cycle
//   tap_idx, tap_last     tap index of the valid data / final tap of the pair
//   out_row, out_col      output row and even output column of the valid data
//   busy, done            pass in progress / one-cycle completion pulse
module img_window_sched
  import img_sched_pkg::*;
#(
  parameter int IMG_W         = IMG_W_DEF,
  parameter int IMG_H         = IMG_H_DEF,
  parameter int K             = K_DEF,
  parameter int LOAD_ADDR_LEN = LOAD_ADDR_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stall,
  output logic                   mem_load,
  output logic [LOAD_ADDR_LEN:0] addr1,
  output logic [LOAD_ADDR_LEN:0] addr2,
  output logic                   tap_valid,
  output logic [3:0]             tap_idx,
  output logic                   tap_last,
  output logic [3:0]             out_row,
  output logic [3:0]             out_col,
  output logic                   busy,
  output logic                   done
);

  localparam int         AW      = LOAD_ADDR_LEN + 1;
  localparam logic [3:0] TAP_MAX = 4'(K * K - 1);

  state_t     state, state_nxt;
  logic       issue;
  logic       last;
  logic [3:0] tap;
  logic [3:0] r;
  logic [3:0] c;

  win_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .ADDR_W (AW)
  ) u_gen (
    .clk     (clk),
    .rst     (rst),
    .advance (issue),
    .addr1   (addr1),
    .tap     (tap),
    .r       (r),
    .c       (c),
    .last    (last)
  );

  assign addr2 = addr1 + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        issue = ~stall;
        if (issue && last) state_nxt = FLUSH;
      end
      // FLUSH exists only to present the final tap; stall is irrelevant here
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_load = issue;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // One stage behind issue to line up with the memory's read latency.
  // Sideband holds between taps; tap_last is qualified so it never
  // lingers into a cycle without valid data.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_valid <= 1'b0;
      tap_last  <= 1'b0;
      tap_idx   <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      tap_valid <= issue;
      tap_last  <= issue && (tap == TAP_MAX);
      if (issue) begin
        tap_idx <= tap;
        out_row <= r;
        out_col <= c;
      end
    end
  end

endmodule

// File: tb/tb_img_window_sched.sv
// tb/tb_img_window_sched.sv - self-checking bench for img_window_sched
module tb_img_window_sched;

  localparam int IMG_W = 14;
  localparam int IMG_H = 14;
  localparam int K     = 3;
  localparam int LAL   = 7;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int TAPS  = K * K;
  localparam int TOTAL = OUT_H * (OUT_W / 2) * TAPS;

  typedef struct {
    int a1;
    int tidx;
    int row;
    int col;
  } tap_t;

  typedef struct {
    string name;
    int    idx;
    int    a1;
    int    a2;
    int    row;
    int    col;
    int    tidx;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stall;
  logic         mem_load;
  logic [LAL:0] addr1;
  logic [LAL:0] addr2;
  logic         tap_valid;
  logic [3:0]   tap_idx;
  logic         tap_last;
  logic [3:0]   out_row;
  logic [3:0]   out_col;
  logic         busy;
  logic         done;

  img_window_sched #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .LOAD_ADDR_LEN(LAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .mem_load  (mem_load),
    .addr1     (addr1),
    .addr2     (addr2),
    .tap_valid (tap_valid),
    .tap_idx   (tap_idx),
    .tap_last  (tap_last),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  tap_t model[$];
  int   rec_a1[TOTAL];
  int   rec_a2[TOTAL];
  tap_t rec_t[TOTAL];
  vec_t vecs[5];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference sequence: the window walk written directly from the iteration order
  task automatic build_model();
    tap_t t;
    model.delete();
    for (int r = 0; r < OUT_H; r++)
      for (int c = 0; c < OUT_W; c += 2)
        for (int kr = 0; kr < K; kr++)
          for (int kc = 0; kc < K; kc++) begin
            t.a1   = (r + kr) * IMG_W + c + kc;
            t.tidx = kr * K + kc;
            t.row  = r;
            t.col  = c;
            model.push_back(t);
          end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mem_load"}, mem_load, 0);
    chk({tag, "_addr1"}, addr1, 0);
    chk({tag, "_addr2"}, addr2, 1);
    chk({tag, "_tap_valid"}, tap_valid, 0);
    chk({tag, "_tap_idx"}, tap_idx, 0);
    chk({tag, "_tap_last"}, tap_last, 0);
    chk({tag, "_out_row"}, out_row, 0);
    chk({tag, "_out_col"}, out_col, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic run_pass(input int stall_pct, input bit noise, input int abort_at, input bit record);
    int   n_issue = 0;
    int   n_tap   = 0;
    int   post    = 0;
    int   cyc     = 0;
    bit   pend_v  = 0;
    bit   have_last = 0;
    tap_t pend;
    tap_t held;
    @(negedge clk);
    start = 1'b1;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      stall = ($urandom_range(0, 99) < stall_pct);
      #1;
      cyc++;
      if (cyc > 4000) begin
        chk("pass_timeout", 0, 1);
        return;
      end
      chk("mem_load", mem_load, (n_issue < TOTAL) && !stall);
      if (n_issue < TOTAL) begin
        chk("addr1", addr1, model[n_issue].a1);
        chk("addr2", addr2, model[n_issue].a1 + 1);
      end
      chk("tap_valid", tap_valid, pend_v);
      chk("tap_last", tap_last, pend_v && (pend.tidx == TAPS - 1));
      if (pend_v) begin
        held      = pend;
        have_last = 1;
      end
      if (have_last) begin
        chk("tap_idx", tap_idx, held.tidx);
        chk("out_row", out_row, held.row);
        chk("out_col", out_col, held.col);
      end
      if (pend_v) begin
        if (record) rec_t[n_tap] = '{int'(tap_idx), int'(tap_idx), int'(out_row), int'(out_col)};
        n_tap++;
      end
      chk("done", done, post == 1);
      chk("busy", busy, post < 2);
      if (post == 2) begin
        chk("issue_count", n_issue, TOTAL);
        return;
      end
      if (post == 1) post = 2;
      else if (pend_v && n_tap == TOTAL) post = 1;
      pend_v = 0;
      if (mem_load && n_issue < TOTAL) begin
        if (record) begin
          rec_a1[n_issue] = addr1;
          rec_a2[n_issue] = addr2;
        end
        pend   = model[n_issue];
        pend_v = 1;
        n_issue++;
      end
      if (abort_at > 0 && n_issue == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (noise && post < 2) start = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    vecs[0] = '{"first",  0,   0,   1,   0,  0, 0};
    vecs[1] = '{"tap8",   8,   30,  31,  0,  0, 8};
    vecs[2] = '{"win_c2", 9,   2,   3,   0,  2, 0};
    vecs[3] = '{"row1",   54,  14,  15,  1,  0, 0};
    vecs[4] = '{"last",   647, 194, 195, 11, 10, 8};

    build_model();
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_idle("reset");

    run_pass(0, 0, 0, 1);
    foreach (vecs[i]) begin
      chk({vecs[i].name, "_addr1"}, rec_a1[vecs[i].idx], vecs[i].a1);
      chk({vecs[i].name, "_addr2"}, rec_a2[vecs[i].idx], vecs[i].a2);
      chk({vecs[i].name, "_row"}, rec_t[vecs[i].idx].row, vecs[i].row);
      chk({vecs[i].name, "_col"}, rec_t[vecs[i].idx].col, vecs[i].col);
      chk({vecs[i].name, "_tidx"}, rec_t[vecs[i].idx].tidx, vecs[i].tidx);
    end

    run_pass(30, 0, 0, 0);
    run_pass(30, 1, 0, 0);

    run_pass(0, 0, 300, 0);
    #1;
    chk_idle("abort");
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("abort_no_done", done, 0);
      chk("abort_no_busy", busy, 0);
    end

    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    #1;
    chk_idle("rst_start");
    @(negedge clk);
    #1;
    chk("rst_start_busy2", busy, 0);
    chk("rst_start_load2", mem_load, 0);

    run_pass(20, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/img_window_sched.md
Name: img_window_sched

Overview:
- Read scheduler for the 16-channel image memory bank (shared addr1/addr2 across all channels, 1-cycle synchronous read).
- Walks a KxK convolution window over an IMG_H x IMG_W channel image, computing two horizontally adjacent output pixels per window pass.
- Port 1 fetches taps for output column c; port 2 fetches taps for column c+1.
- Feeds the downstream MAC array with tap-aligned valid/index/position sideband.

Parameters:
- IMG_W, 14, image width in pixels.
- IMG_H, 14, image height in pixels.
- K, 3, kernel side. Taps per window = K*K.
- LOAD_ADDR_LEN, 7, address MSB index; address width = LOAD_ADDR_LEN+1.
- Legal configurations:
  - OUT_W = IMG_W-K+1 must be even.
  - IMG_W*IMG_H <= 2^(LOAD_ADDR_LEN+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin one full channel-image pass. Sampled only in IDLE.
- stall  in  1  downstream back-pressure. Freezes issue.
- mem_load  out  1  read enable to the memory bank.
- addr1  out  LOAD_ADDR_LEN+1  read address, port 1 (even output column).
- addr2  out  LOAD_ADDR_LEN+1  read address, port 2 (= addr1+1).
- tap_valid  out  1  memory dout1/dout2 carry a valid tap this cycle.
- tap_idx  out  4  tap index kr*K+kc for the data currently valid.
- tap_last  out  1  tap_valid and tap_idx = K*K-1. Window pair complete.
- out_row  out  4  output row r of the current data.
- out_col  out  4  even output column c of the current data. The pair is c, c+1.
- busy  out  1  high from the cycle after start is accepted through the done cycle.
- done  out  1  one-cycle pulse after the final tap_valid.

Behaviour:
- Reset:
  - rst at any clk edge, including mid-pass, forces IDLE.
  - All outputs 0, all counters 0. No partial-pass completion, no done pulse.
- States: IDLE -> RUN -> FLUSH -> DONE -> IDLE.
- IDLE:
  - start=1 at edge t moves to RUN. The first issue happens in cycle t+1.
  - start is ignored in RUN, FLUSH and DONE.
- Issue in RUN:
  - issue = (state==RUN) & ~stall.
  - mem_load = issue, combinational from state and stall.
  - Iteration order, innermost first: kc 0..K-1, kr 0..K-1, c 0..OUT_W-2 step 2, r 0..OUT_H-1.
  - addr1 = (r+kr)*IMG_W + c + kc. addr2 = addr1+1.
  - Addresses come from registered counters only: row_base accumulates IMG_W, plus column adds. No multipliers.
  - Counters advance only on issue.
- Stall:
  - Counters and addr1/addr2 hold, mem_load=0.
  - No issue is lost or duplicated.
- Read pipeline:
  - tap_valid(t+1) = issue(t).
  - tap_idx, tap_last, out_row, out_col are the values of the issue at t, registered one stage.
  - They hold their values while tap_valid=0.
- RUN -> FLUSH: on the issue with r=OUT_H-1, c=OUT_W-2, kr=kc=K-1.
- FLUSH: one cycle. The last tap_valid (tap_last=1) is asserted here. stall has no effect in FLUSH.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- Issue count per pass: OUT_H*(OUT_W/2)*K*K. Default is 12*6*9 = 648.
- Address bounds: max addr2 = IMG_W*IMG_H-1, which is 195 by default. No wrap-around is possible for legal parameters.
- Reset in the same cycle as start: reset wins.

Decomposition:
- Shared package img_sched_pkg holds:
  - localparams OUT_W, OUT_H, TAPS=K*K, ADDR_W=LOAD_ADDR_LEN+1.
  - state enum {IDLE, RUN, FLUSH, DONE}.
- One sub-module, win_addr_gen, holds the nested kc/kr/c/r counters, the row_base accumulator and the last-issue flag, with an advance input.
- The top holds the FSM and the one-stage sideband pipeline.

Test Plan:
- Basic start: start pulse at cycle 0.
  - Cycle 1: mem_load=1, addr1=0, addr2=1.
  - Cycle 2: tap_valid=1, tap_idx=0, out_row=0, out_col=0.
  - 9th issue: addr1=30, addr2=31. The next cycle has tap_last=1.
- Full pass, no stall:
  - Exactly 648 mem_load cycles.
  - Last issue addr1=194, addr2=195 with out_row=11, out_col=10.
  - FLUSH shows tap_last=1, the following cycle shows done=1, then busy=0.
- Stall:
  - Random stall at 30% density.
  - Scoreboard sees the identical 648-entry address/tap sequence in order, with no duplicates.
  - addr1/addr2 stay frozen while stalled.
- Reset mid-pass: rst at issue #300.
  - Next cycle: IDLE, all outputs 0, no done.
  - A new start restarts at addr1=0.
- Start while busy: extra start pulses during RUN and DONE are ignored. Total issue count stays 648, with exactly one done.
- Window boundary: after window (r=0, c=0) completes, the next issue is addr1=2 for (r=0, c=2). After c=10, the next is addr1=14 for (r=1, c=0).
